// File: rtl/rom_disp_pkg.sv
// Shared constants, glyph field positions and FSM encoding for the ROM-fed
// 7-segment message scroller.
package rom_disp_pkg;

    localparam int WORD_W     = 16;
    localparam int GLYPH_W    = 7;
    localparam int NUM_DIGITS = 8;
    localparam int WIN_WORDS  = 4;
    localparam int PAIR_W     = 2 * GLYPH_W;

    // Each ROM word carries two glyphs; the top two bits are don't-care.
    localparam int LEFT_MSB  = 13;
    localparam int LEFT_LSB  = 7;
    localparam int RIGHT_MSB = 6;
    localparam int RIGHT_LSB = 0;

    localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 7'h00;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_SWAP    = 3'd3,
        S_SHOW    = 3'd4
    } state_t;

    function automatic int wrap_mod(input int sum, input int len);
        return sum % len;
    endfunction

endpackage

// File: rtl/rom_msg_scroller_seg_scan.sv
// Digit scan for an 8-digit multiplexed display: divider, digit counter
// (7 down to 0, wrapping) and the active-low anode / segment output mux.
module seg_scan_mux
    import rom_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_en,
    input  logic [NUM_DIGITS-1:0][GLYPH_W-1:0]    i_glyphs,
    output logic [GLYPH_W-1:0]                    o_seg,
    output logic [NUM_DIGITS-1:0]                 o_an
);

    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int DIG_W = $clog2(NUM_DIGITS);

    logic [DIV_W-1:0] r_div;
    logic [DIG_W-1:0] r_digit;

    // Disabling parks the scan on the leftmost digit so every restart looks alike.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_digit <= DIG_W'(NUM_DIGITS - 1);
        end else if (!i_en) begin
            r_div   <= '0;
            r_digit <= DIG_W'(NUM_DIGITS - 1);
        end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
            r_div   <= '0;
            r_digit <= r_digit - 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_comb begin
        o_an  = '1;
        o_seg = GLYPH_BLANK;
        if (i_en) begin
            o_an[r_digit] = 1'b0;
            o_seg         = i_glyphs[r_digit];
        end
    end

endmodule

// File: rtl/rom_msg_scroller.sv
// ROM read master that fetches a 4-word glyph window and shows it on an
// 8-digit display; scrolling is compiled in only when MSG_SCROLL_EN is defined.
module rom_msg_scroller
    import rom_disp_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int BASE_ADDR  = 0,
    parameter int MSG_LEN    = 6,
    parameter int SCAN_DIV   = 50000,
    parameter int SCROLL_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [WORD_W-1:0]     rom_data,
    output logic                  cs_rom,
    output logic [ADDR_W-1:0]     rom_addr,
    output logic [GLYPH_W-1:0]    seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  busy,
    output logic                  win_loaded,
    output state_t                dbg_state
);

    localparam int BASE_W = $clog2(MSG_LEN + 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [BASE_W-1:0]     r_base;
    logic [1:0]            r_idx;
    logic [PAIR_W-1:0]     r_load_buf [WIN_WORDS];
    logic [PAIR_W-1:0]     r_disp_buf [WIN_WORDS];
    logic                  r_cs_rom;
    logic [ADDR_W-1:0]     r_rom_addr;
    logic                  w_scan_en;
    int                    w_fetch_sum;
    logic [NUM_DIGITS-1:0][GLYPH_W-1:0] w_glyphs;
    logic                  w_unused_rom_hi;

`ifdef MSG_SCROLL_EN
    localparam int SC_W = $clog2(SCROLL_DIV + 1);
    logic [SC_W-1:0]       r_scroll_cnt;
    logic                  w_scroll_done;
`else
    localparam int unused_scroll_div = SCROLL_DIV;
`endif

    assign w_unused_rom_hi = ^rom_data[WORD_W-1:PAIR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (stop) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (start) w_next_state = S_FETCH;
                S_FETCH:   w_next_state = S_CAPTURE;
                S_CAPTURE: w_next_state = (r_idx == 2'd3) ? S_SWAP : S_FETCH;
                S_SWAP:    w_next_state = S_SHOW;
`ifdef MSG_SCROLL_EN
                S_SHOW:    if (w_scroll_done) w_next_state = S_FETCH;
`else
                S_SHOW:    w_next_state = S_SHOW;
`endif
                default:   w_next_state = S_IDLE;
            endcase
        end
    end

    // The address is registered one cycle early, so it is built from the
    // base/idx values that will hold once FETCH is entered.
    always_comb begin
        busy        = (r_state != S_IDLE);
        win_loaded  = (r_state == S_SWAP);
        w_scan_en   = (r_state != S_IDLE);
        w_fetch_sum = 0;
        case (r_state)
            S_CAPTURE: w_fetch_sum = int'(r_base) + int'(r_idx) + 1;
            S_SHOW:    w_fetch_sum = int'(r_base) + 1;
            default:   w_fetch_sum = 0;
        endcase
`ifdef MSG_SCROLL_EN
        w_scroll_done = (r_scroll_cnt == SC_W'(SCROLL_DIV - 1));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_rom   <= 1'b0;
            r_rom_addr <= '0;
            r_base     <= '0;
            r_idx      <= '0;
            for (int w = 0; w < WIN_WORDS; w++) begin
                r_load_buf[w] <= '0;
                r_disp_buf[w] <= '0;
            end
`ifdef MSG_SCROLL_EN
            r_scroll_cnt <= '0;
`endif
        end else if (stop) begin
            r_cs_rom <= 1'b0;
            r_base   <= '0;
            r_idx    <= '0;
            for (int w = 0; w < WIN_WORDS; w++) begin
                r_load_buf[w] <= '0;
                r_disp_buf[w] <= '0;
            end
`ifdef MSG_SCROLL_EN
            r_scroll_cnt <= '0;
`endif
        end else begin
            r_cs_rom <= (w_next_state == S_FETCH);
            if (w_next_state == S_FETCH)
                r_rom_addr <= ADDR_W'(BASE_ADDR + wrap_mod(w_fetch_sum, MSG_LEN));
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base <= '0;
                        r_idx  <= '0;
                    end
                end
                S_CAPTURE: begin
                    r_load_buf[r_idx] <= rom_data[PAIR_W-1:0];
                    r_idx             <= r_idx + 1'b1;
                end
                S_SWAP: begin
                    for (int w = 0; w < WIN_WORDS; w++)
                        r_disp_buf[w] <= r_load_buf[w];
                end
`ifdef MSG_SCROLL_EN
                S_SHOW: begin
                    if (w_scroll_done) begin
                        r_scroll_cnt <= '0;
                        r_base       <= BASE_W'(wrap_mod(int'(r_base) + 1, MSG_LEN));
                        r_idx        <= '0;
                    end else begin
                        r_scroll_cnt <= r_scroll_cnt + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Word w of the window lands on digits 7-2w (left) and 6-2w (right).
    always_comb begin
        w_glyphs = '0;
        for (int w = 0; w < WIN_WORDS; w++) begin
            w_glyphs[NUM_DIGITS-1-2*w] = r_disp_buf[w][LEFT_MSB:LEFT_LSB];
            w_glyphs[NUM_DIGITS-2-2*w] = r_disp_buf[w][RIGHT_MSB:RIGHT_LSB];
        end
    end

    seg_scan_mux #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_scan_en),
        .i_glyphs (w_glyphs),
        .o_seg    (seg),
        .o_an     (an)
    );

    assign cs_rom    = r_cs_rom;
    assign rom_addr  = r_rom_addr;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_rom_msg_scroller.sv
// Directed bench for rom_msg_scroller with a 1-cycle registered ROM model
// holding the six-word demo message.
module tb_rom_msg_scroller;
    import rom_disp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] rom_data = '0;
    logic        cs_rom;
    logic [9:0]  rom_addr;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        busy;
    logic        win_loaded;
    state_t      dbg_state;

    logic [15:0] mem [1024];
    logic [15:0] msg [6];
    logic [6:0]  exp0 [8];

    int n_tests = 0;
    int n_fail  = 0;
    int bad, d, prev, cs_cnt, naddr, got_wl, cur_base;
    logic seen7, seen0;
    logic [9:0] addrs [4];

    always #5 clk = ~clk;

    always @(posedge clk) if (cs_rom) rom_data <= mem[rom_addr];

    rom_msg_scroller #(
        .ADDR_W     (10),
        .BASE_ADDR  (0),
        .MSG_LEN    (6),
        .SCAN_DIV   (4),
        .SCROLL_DIV (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .rom_data   (rom_data),
        .cs_rom     (cs_rom),
        .rom_addr   (rom_addr),
        .seg        (seg),
        .an         (an),
        .busy       (busy),
        .win_loaded (win_loaded),
        .dbg_state  (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    function automatic int digit_of(input logic [7:0] a);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m = 8'b1 << i;
            if (a == ~m) return i;
        end
        return -1;
    endfunction

`ifdef MSG_SCROLL_EN
    function automatic logic [6:0] glyph_at(input int b, input int dig);
        logic [15:0] word;
        word = msg[(b + (7 - dig) / 2) % 6];
        return (dig % 2 == 1) ? word[13:7] : word[6:0];
    endfunction
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        msg[0] = 16'h034F; msg[1] = 16'h0366; msg[2] = 16'h1C3F;
        msg[3] = 16'h1F79; msg[4] = 16'h006E; msg[5] = 16'h1FBE;
        exp0[7] = 7'h06; exp0[6] = 7'h4F; exp0[5] = 7'h06; exp0[4] = 7'h66;
        exp0[3] = 7'h38; exp0[2] = 7'h3F; exp0[1] = 7'h3E; exp0[0] = 7'h79;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom_range(32'h3FFF, 32'h0081));
        for (int i = 0; i < 6; i++) mem[i] = msg[i];

        // Reset values
        ticks(3);
        check("rst_cs_rom", cs_rom, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_seg", seg, 0);
        check("rst_an", an, 8'hFF);
        check("rst_busy", busy, 0);
        check("rst_win_loaded", win_loaded, 0);
        check("rst_state", dbg_state, S_IDLE);
        rst_n = 1'b1;
        tick();

        // First window load: addresses 0..3 on alternate cycles, win_loaded 9 cycles on
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            check("fetch_cs", cs_rom, 1);
            check("fetch_addr", rom_addr, i);
            check("fetch_no_wl", win_loaded, 0);
            tick();
            check("capture_cs", cs_rom, 0);
            tick();
        end
        check("win_loaded_at_9", win_loaded, 1);
        check("swap_state", dbg_state, S_SWAP);
        tick();
        check("win_loaded_pulse", win_loaded, 0);

        // Scan of the first window
        bad = 0; prev = -1; seen7 = 0; seen0 = 0;
        for (int c = 0; c < 40; c++) begin
            d = digit_of(an);
            if (d < 0 || seg !== exp0[d]) bad++;
            if (prev >= 0 && d != prev && d != (prev + 7) % 8) bad++;
            prev = d;
            if (an == 8'b0111_1111 && !seen7) begin
                check("digit7_seg", seg, 7'b0000110);
                seen7 = 1;
            end
            if (an == 8'b1111_1110 && !seen0) begin
                check("digit0_seg", seg, 7'b1111001);
                seen0 = 1;
            end
            tick();
        end
        check("scan_errors", bad, 0);
        check("scan_saw_d7", seen7, 1);
        check("scan_saw_d0", seen0, 1);

`ifdef MSG_SCROLL_EN
        // Six scrolls: fetch addresses wrap mod 6, display holds the old window until swap
        cur_base = 0;
        for (int k = 1; k <= 6; k++) begin
            naddr = 0; bad = 0; got_wl = 0;
            for (int c = 0; c < 200 && got_wl == 0; c++) begin
                if (cs_rom) begin
                    if (naddr < 4) addrs[naddr] = rom_addr;
                    naddr++;
                end
                d = digit_of(an);
                if (d < 0 || seg !== glyph_at(cur_base, d)) bad++;
                if (win_loaded) got_wl = 1;
                tick();
            end
            check("scroll_wl_seen", got_wl, 1);
            check("scroll_fetch_count", naddr, 4);
            for (int i = 0; i < 4; i++) check("scroll_addr", addrs[i], (k + i) % 6);
            check("scroll_no_glitch", bad, 0);
            cur_base = k % 6;
        end
`else
        // Terminal SHOW: no more reads, digits constant
        cs_cnt = 0; bad = 0;
        for (int c = 0; c < 1000; c++) begin
            if (cs_rom) cs_cnt++;
            d = digit_of(an);
            if (d < 0 || seg !== exp0[d]) bad++;
            tick();
        end
        check("hold_no_cs", cs_cnt, 0);
        check("hold_digits", bad, 0);
        check("hold_state", dbg_state, S_SHOW);
`endif

        // stop from SHOW
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_an", an, 8'hFF);
        check("stop_seg", seg, 0);
        check("stop_state", dbg_state, S_IDLE);

        // stop during CAPTURE of idx=2
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(5);
        check("cap2_state", dbg_state, S_CAPTURE);
        check("cap2_addr", rom_addr, 2);
        check("cleared_buf_seg", seg, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("cap2_stop_state", dbg_state, S_IDLE);
        check("cap2_stop_an", an, 8'hFF);
        check("cap2_stop_cs", cs_rom, 0);
        cs_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (cs_rom) cs_cnt++;
            tick();
        end
        check("cap2_no_more_cs", cs_cnt, 0);

        // start together with stop: stop wins
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("both_busy", busy, 0);
        check("both_cs", cs_rom, 0);
        ticks(5);
        check("both_still_idle", busy, 0);

        // Lone start reloads from address 0
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_cs", cs_rom, 1);
        check("restart_addr", rom_addr, 0);
        ticks(2);
        check("restart_cs2", cs_rom, 1);
        check("restart_addr2", rom_addr, 1);

        // Asynchronous reset in the middle of a fetch
        rst_n = 1'b0;
        #1;
        check("async_rst_cs", cs_rom, 0);
        check("async_rst_an", an, 8'hFF);
        check("async_rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_cs", cs_rom, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
